// File: rtl/pwm_tff_controller.sv
// pwm_tff_controller
//   PWM generator built around a WIDTH-bit synchronous counter made of toggle
//   cells (cnt <= cnt ^ t_vec).  Period/duty configuration arrives over a
//   valid/ready handshake into shadow registers.  The shadow values are copied
//   to the active registers only at a period boundary, or immediately when
//   idle, so the running waveform never glitches.
//
//   Optional build macro: PWM_DEADTIME_EN
//     defined     : pwm_n is the complement of pwm, and each rising edge of
//                   either output waits DEAD cycles after the other output
//                   falls.  Pulses shorter than DEAD are swallowed.
//     not defined : pwm_n is the plain complement while running; DEAD unused.
//
//   Ports
//     clk         system clock, rising edge
//     rst         synchronous active-high reset
//     en          run request
//     cfg_valid   configuration offered
//     cfg_ready   shadow register free (no configuration pending)
//     cfg_period  terminal count, period = cfg_period + 1 cycles
//     cfg_duty    high time in cycles
//     cnt         toggle-cell counter value
//     period_end  high while running and cnt == active period
//     pwm         registered PWM output
//     pwm_n       registered complementary output
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | counter held at 0, outputs low, shadow applied immediately
//   RUN   | counting, shadow applied at period_end
//   STOP  | en dropped; finish the current period, then IDLE
module pwm_tff_controller #(
    parameter int WIDTH = 8,
    parameter int DEAD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic [WIDTH-1:0] cnt,
    output logic             period_end,
    output logic             pwm,
    output logic             pwm_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] period_sh;
    logic [WIDTH-1:0] duty_sh;
    logic             pending;
    logic [WIDTH-1:0] t_vec;
    logic             carry;
    logic             running;
    logic             at_tc;
    logic             xfer;
    logic             apply;
    logic             duty_hi;

    assign running    = (state != S_IDLE);
    assign at_tc      = (cnt == period_q);
    assign period_end = running && at_tc;
    assign cfg_ready  = ~pending;
    assign xfer       = cfg_valid && !pending;
    // Idle applies at once; while running only at the wrap edge.
    assign apply      = pending && (!running || at_tc);
    assign duty_hi    = (cnt < duty_q);

    // Toggling every set bit clears the counter; the ripple-AND chain
    // toggles bit i when all lower bits are 1, giving an increment.
    always_comb begin
        t_vec = cnt;
        carry = 1'b1;
        if (!rst && running && !at_tc) begin
            for (int i = 0; i < WIDTH; i++) begin
                t_vec[i] = carry;
                carry    = carry & cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt ^ t_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (en) state <= S_RUN;
                S_RUN:   if (!en) state <= S_STOP;
                S_STOP: begin
                    if (en)         state <= S_RUN;
                    else if (at_tc) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            period_sh <= '0;
            duty_sh   <= '0;
            period_q  <= '0;
            duty_q    <= '0;
        end else begin
            if (apply) begin
                period_q <= period_sh;
                duty_q   <= duty_sh;
            end
            if (xfer) begin
                period_sh <= cfg_period;
                duty_sh   <= cfg_duty;
                pending   <= 1'b1;
            end else if (apply) begin
                pending   <= 1'b0;
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam int            DW      = (DEAD < 1) ? 1 : $clog2(DEAD + 1);
    localparam logic [DW-1:0] DEAD_LD = DW'(DEAD);

    logic [DW-1:0] dt_p;
    logic [DW-1:0] dt_n;
    logic          nom_p;
    logic          nom_n;

    assign nom_p = running && duty_hi;
    assign nom_n = running && !duty_hi;

    // Each output's timer reloads while its nominal level is low and counts
    // down while high; the output rises only once the timer has expired.
    // nom_p and nom_n are exclusive, so both outputs can never be high.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm   <= 1'b0;
            pwm_n <= 1'b0;
            dt_p  <= DEAD_LD;
            dt_n  <= DEAD_LD;
        end else begin
            if (!nom_p) begin
                pwm  <= 1'b0;
                dt_p <= DEAD_LD;
            end else if (dt_p == '0) begin
                pwm  <= 1'b1;
            end else begin
                dt_p <= dt_p - DW'(1);
            end

            if (!nom_n) begin
                pwm_n <= 1'b0;
                dt_n  <= DEAD_LD;
            end else if (dt_n == '0) begin
                pwm_n <= 1'b1;
            end else begin
                dt_n  <= dt_n - DW'(1);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm   <= 1'b0;
            pwm_n <= 1'b0;
        end else begin
            pwm   <= running && duty_hi;
            pwm_n <= running && !duty_hi;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_tff_controller.sv
module tb_pwm_tff_controller;
    localparam int WIDTH = 8;
    localparam int DEAD  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_duty;
    logic [WIDTH-1:0] cnt;
    logic             period_end;
    logic             pwm;
    logic             pwm_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_tff_controller #(.WIDTH(WIDTH), .DEAD(DEAD)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cnt        (cnt),
        .period_end (period_end),
        .pwm        (pwm),
        .pwm_n      (pwm_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] d);
        int n;
        cfg_period = p;
        cfg_duty   = d;
        cfg_valid  = 1'b1;
        n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_accept_timeout: cfg_ready=%0b expected 1", cfg_ready);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    // Leaves the DUT in RUN with cnt=0 and the given period/duty active.
    task automatic start_run(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] d);
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        tick();
        rst = 1'b0;
        send_cfg(p, d);
        tick();
        en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        start_run(8'd9, 8'd3);
        repeat (5) tick();
        checks++;
        if (cnt !== 8'd5) begin
            errors++; $display("FAIL pre_reset_cnt: got %0d expected 5", cnt);
        end
        rst = 1'b1; cfg_valid = 1'b1; cfg_period = 8'd7; cfg_duty = 8'd7;
        tick();
        rst = 1'b0; cfg_valid = 1'b0; en = 1'b0;
        checks++;
        if (cnt !== 8'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt);
        end
        checks++;
        if (pwm !== 1'b0 || pwm_n !== 1'b0) begin
            errors++; $display("FAIL reset_pwm: pwm=%0b pwm_n=%0b expected 0 0", pwm, pwm_n);
        end
        checks++;
        if (cfg_ready !== 1'b1 || period_end !== 1'b0) begin
            errors++; $display("FAIL reset_ready_pe: cfg_ready=%0b period_end=%0b expected 1 0", cfg_ready, period_end);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (cnt !== 8'd0 || period_end !== 1'b0) begin
                errors++; $display("FAIL idle_hold: cnt=%0d period_end=%0b expected 0 0", cnt, period_end);
            end
        end
        // Active period was cleared by reset, so running now wraps every cycle.
        en = 1'b1;
        tick();
        tick();
        checks++;
        if (cnt !== 8'd0 || period_end !== 1'b1) begin
            errors++; $display("FAIL reset_period_zero: cnt=%0d period_end=%0b expected 0 1", cnt, period_end);
        end
        en = 1'b0;
    endtask

    task automatic test_basic();
        int exp_cnt;
        int prev;
        int hi;
        int pe;
        start_run(8'd9, 8'd3);
        tick();
        exp_cnt = 1;
        hi = 0;
        pe = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            prev = exp_cnt;
            exp_cnt = (exp_cnt == 9) ? 0 : exp_cnt + 1;
            checks++;
            if (cnt !== exp_cnt[WIDTH-1:0] || period_end !== (exp_cnt == 9)) begin
                errors++; $display("FAIL basic_cnt: cnt=%0d period_end=%0b expected %0d %0b", cnt, period_end, exp_cnt, (exp_cnt == 9));
            end
`ifndef PWM_DEADTIME_EN
            checks++;
            if (pwm !== (prev < 3) || pwm_n !== !(prev < 3)) begin
                errors++; $display("FAIL basic_pwm: pwm=%0b pwm_n=%0b expected %0b %0b at cnt %0d", pwm, pwm_n, (prev < 3), !(prev < 3), exp_cnt);
            end
`endif
            if (pwm === 1'b1) hi++;
            if (period_end === 1'b1) pe++;
        end
`ifndef PWM_DEADTIME_EN
        checks++;
        if (hi != 6) begin
            errors++; $display("FAIL basic_high_count: got %0d expected 6", hi);
        end
`endif
        checks++;
        if (pe != 2) begin
            errors++; $display("FAIL basic_pe_count: got %0d expected 2", pe);
        end
    endtask

    task automatic test_boundary();
        int hi;
        int lo;
        start_run(8'd9, 8'd0);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pwm !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++; $display("FAIL duty0_const_low: high cycles=%0d expected 0", hi);
        end

        start_run(8'd9, 8'd10);
        repeat (4) tick();
        lo = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pwm !== 1'b1) lo++;
        end
        checks++;
        if (lo != 0) begin
            errors++; $display("FAIL duty_over_const_high: low cycles=%0d expected 0", lo);
        end

        start_run(8'd0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (cnt !== 8'd0 || period_end !== 1'b1) begin
                errors++; $display("FAIL period0: cnt=%0d period_end=%0b expected 0 1", cnt, period_end);
            end
            tick();
        end
    endtask

    task automatic test_shadow();
        start_run(8'd9, 8'd3);
        repeat (2) tick();
        cfg_period = 8'd4; cfg_duty = 8'd2; cfg_valid = 1'b1;
        checks++;
        if (cnt !== 8'd2 || cfg_ready !== 1'b1) begin
            errors++; $display("FAIL shadow_pre: cnt=%0d cfg_ready=%0b expected 2 1", cnt, cfg_ready);
        end
        tick();
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++; $display("FAIL shadow_ready_drop: cfg_ready=%0b expected 0", cfg_ready);
        end
        cfg_period = 8'd7; cfg_duty = 8'd1; cfg_valid = 1'b1;
        repeat (6) tick();
        checks++;
        if (cnt !== 8'd9 || period_end !== 1'b1 || cfg_ready !== 1'b0) begin
            errors++; $display("FAIL shadow_old_period: cnt=%0d period_end=%0b cfg_ready=%0b expected 9 1 0", cnt, period_end, cfg_ready);
        end
        tick();
        checks++;
        if (cnt !== 8'd0 || cfg_ready !== 1'b1) begin
            errors++; $display("FAIL shadow_apply: cnt=%0d cfg_ready=%0b expected 0 1", cnt, cfg_ready);
        end
        tick();
        checks++;
        if (cnt !== 8'd1 || cfg_ready !== 1'b0) begin
            errors++; $display("FAIL shadow_second_accept: cnt=%0d cfg_ready=%0b expected 1 0", cnt, cfg_ready);
        end
        cfg_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (cnt !== 8'd4 || period_end !== 1'b1) begin
            errors++; $display("FAIL shadow_new_period: cnt=%0d period_end=%0b expected 4 1", cnt, period_end);
        end
        tick();
        checks++;
        if (cnt !== 8'd0 || cfg_ready !== 1'b1) begin
            errors++; $display("FAIL shadow_second_apply: cnt=%0d cfg_ready=%0b expected 0 1", cnt, cfg_ready);
        end
        repeat (7) tick();
        checks++;
        if (cnt !== 8'd7 || period_end !== 1'b1) begin
            errors++; $display("FAIL shadow_third_period: cnt=%0d period_end=%0b expected 7 1", cnt, period_end);
        end
    endtask

    task automatic test_stop();
        start_run(8'd9, 8'd3);
        repeat (4) tick();
        en = 1'b0;
        tick();
        checks++;
        if (cnt !== 8'd5) begin
            errors++; $display("FAIL stop_keeps_counting: cnt=%0d expected 5", cnt);
        end
        repeat (4) tick();
        checks++;
        if (cnt !== 8'd9 || period_end !== 1'b1) begin
            errors++; $display("FAIL stop_last_period: cnt=%0d period_end=%0b expected 9 1", cnt, period_end);
        end
        tick();
        checks++;
        if (cnt !== 8'd0 || pwm !== 1'b0) begin
            errors++; $display("FAIL stop_idle_entry: cnt=%0d pwm=%0b expected 0 0", cnt, pwm);
        end
        tick();
        checks++;
        if (pwm_n !== 1'b0 || pwm !== 1'b0 || period_end !== 1'b0) begin
            errors++; $display("FAIL stop_idle_outputs: pwm=%0b pwm_n=%0b period_end=%0b expected 0 0 0", pwm, pwm_n, period_end);
        end
        repeat (3) tick();
        checks++;
        if (cnt !== 8'd0) begin
            errors++; $display("FAIL stop_idle_hold: cnt=%0d expected 0", cnt);
        end

        start_run(8'd9, 8'd3);
        repeat (4) tick();
        en = 1'b0;
        repeat (2) tick();
        en = 1'b1;
        tick();
        repeat (2) tick();
        checks++;
        if (cnt !== 8'd9 || period_end !== 1'b1) begin
            errors++; $display("FAIL cancel_stop_tc: cnt=%0d period_end=%0b expected 9 1", cnt, period_end);
        end
        repeat (2) tick();
        checks++;
        if (cnt !== 8'd1) begin
            errors++; $display("FAIL cancel_stop_running: cnt=%0d expected 1", cnt);
        end
    endtask

`ifdef PWM_DEADTIME_EN
    task automatic test_deadtime();
        logic prev_p;
        logic prev_n;
        logic bl1;
        logic bl2;
        int hi_p;
        int hi_n;
        start_run(8'd9, 8'd5);
        prev_p = pwm; prev_n = pwm_n;
        bl1 = !pwm && !pwm_n; bl2 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (pwm === 1'b1 && pwm_n === 1'b1) begin
                errors++; $display("FAIL dt_overlap: pwm=%0b pwm_n=%0b expected not both 1", pwm, pwm_n);
            end
            if ((pwm === 1'b1 && !prev_p) || (pwm_n === 1'b1 && !prev_n)) begin
                checks++;
                if (!(bl1 && bl2)) begin
                    errors++; $display("FAIL dt_gap: low cycles before edge %0b%0b expected 11", bl2, bl1);
                end
            end
            bl2 = bl1;
            bl1 = !pwm && !pwm_n;
            prev_p = pwm; prev_n = pwm_n;
        end
        start_run(8'd9, 8'd1);
        hi_p = 0; hi_n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pwm === 1'b1) hi_p++;
            if (pwm_n === 1'b1) hi_n++;
        end
        checks++;
        if (hi_p != 0 || hi_n == 0) begin
            errors++; $display("FAIL dt_suppress: pwm high=%0d pwm_n high=%0d expected 0 and nonzero", hi_p, hi_n);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0;
        test_reset();
        test_basic();
        test_boundary();
        test_shadow();
        test_stop();
`ifdef PWM_DEADTIME_EN
        test_deadtime();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
